weight_loader: RTL and testbench

// Write-side of the gate weight path: accepts a serial stream of fixed-point weight/bias words, packs them

---
 rtl/weight_loader_pkg.sv | 24 ++
 rtl/weight_loader_column_packer.sv | 33 +++
 rtl/weight_loader.sv | 109 ++++++++++
 tb/tb_weight_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// Shared widths, defaults and FSM encodings for the gate weight loader.
// Word format is two's complement Q(QN).(QM) plus sign bit.
package weight_loader_pkg;

  localparam int DEF_INPUT_SZ  = 2;
  localparam int DEF_HIDDEN_SZ = 16;
  localparam int DEF_QN        = 6;
  localparam int DEF_QM        = 11;

  typedef logic [2:0] loaderState_t;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FILL_X = 3'd1;
  localparam logic [2:0] WR_X   = 3'd2;
  localparam logic [2:0] FILL_Y = 3'd3;
  localparam logic [2:0] WR_Y   = 3'd4;
  localparam logic [2:0] FILL_B = 3'd5;
  localparam logic [2:0] START  = 3'd6;

  function automatic int wordWidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

endpackage

// File: rtl/weight_loader_column_packer.sv
// Packs accepted words into a HIDDEN_SZ-row column; row slot written on the accept edge.
// colFull is combinational on the accept of the last row; caller stalls by withholding wordAccept.
module weight_loader_column_packer
  import weight_loader_pkg::*;
#(
  parameter int HIDDEN_SZ = DEF_HIDDEN_SZ,
  parameter int BITWIDTH  = wordWidth(DEF_QN, DEF_QM),
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int ROW_W = $clog2(HIDDEN_SZ)
)(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [BITWIDTH-1:0]       wordIn,
  input  logic                      wordAccept,
  output logic [ROW_W-1:0]          rowIdx,
  output logic [LAYER_BITWIDTH-1:0] colData,
  output logic                      colFull
);

  assign colFull = wordAccept && (rowIdx == ROW_W'(HIDDEN_SZ - 1));

  // Row counter wraps on the last row so every column and phase starts at row 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rowIdx  <= '0;
      colData <= '0;
    end else if (wordAccept) begin
      rowIdx <= colFull ? '0 : rowIdx + 1'b1;
      colData[rowIdx*BITWIDTH +: BITWIDTH] <= wordIn;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streams weight/bias words into X/Y weightRAM columns and the bias vector, then starts the gate.
// RAM write one cycle after the last row of a column; wordReady drops during writes and outside a load.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int INPUT_SZ  = DEF_INPUT_SZ,
  parameter int HIDDEN_SZ = DEF_HIDDEN_SZ,
  parameter int QN        = DEF_QN,
  parameter int QM        = DEF_QM,
  localparam int BITWIDTH       = wordWidth(QN, QM),
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int XA_W           = $clog2(INPUT_SZ),
  localparam int YA_W           = $clog2(HIDDEN_SZ)
)(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      loadStart,
  input  logic [BITWIDTH-1:0]       wordIn,
  input  logic                      wordValid,
  output logic                      wordReady,
  output logic [XA_W-1:0]           colAddressWrite_X,
  output logic [YA_W-1:0]           colAddressWrite_Y,
  output logic                      writeEn_X,
  output logic                      writeEn_Y,
  output logic [LAYER_BITWIDTH-1:0] weightMemInput_X,
  output logic [LAYER_BITWIDTH-1:0] weightMemInput_Y,
  output logic [LAYER_BITWIDTH-1:0] biasVec,
  output logic                      gateReset,
  output logic                      beginCalc,
  output logic                      busy
);

  loaderState_t             state;
  loaderState_t             nextState;
  logic [YA_W-1:0]          col;
  logic [YA_W-1:0]          rowIdx;
  logic [LAYER_BITWIDTH-1:0] colData;
  logic                     colFull;
  logic                     wordAccept;
  logic                     lastColX;
  logic                     lastColY;

  assign wordReady  = (state == FILL_X) || (state == FILL_Y) || (state == FILL_B);
  assign wordAccept = wordValid && wordReady;
  assign lastColX   = (col == YA_W'(INPUT_SZ - 1));
  assign lastColY   = (col == YA_W'(HIDDEN_SZ - 1));

  weight_loader_column_packer #(
    .HIDDEN_SZ (HIDDEN_SZ),
    .BITWIDTH  (BITWIDTH)
  ) packer (
    .clock      (clock),
    .reset      (reset),
    .wordIn     (wordIn),
    .wordAccept (wordAccept),
    .rowIdx     (rowIdx),
    .colData    (colData),
    .colFull    (colFull)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (loadStart) nextState = FILL_X;
      FILL_X:  if (colFull)   nextState = WR_X;
      WR_X:    nextState = lastColX ? FILL_Y : FILL_X;
      FILL_Y:  if (colFull)   nextState = WR_Y;
      WR_Y:    nextState = lastColY ? FILL_B : FILL_Y;
      FILL_B:  if (colFull)   nextState = START;
      START:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Column counter advances only after the column's write strobe, wrapping at each phase change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
    end else begin
      state <= nextState;
      case (state)
        WR_X:    col <= lastColX ? '0 : col + 1'b1;
        WR_Y:    col <= lastColY ? '0 : col + 1'b1;
        default: col <= col;
      endcase
    end
  end

  // Bias is kept outside the packer so it survives the next load's column traffic slot by slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      biasVec <= '0;
    end else if (state == FILL_B && wordAccept) begin
      biasVec[rowIdx*BITWIDTH +: BITWIDTH] <= wordIn;
    end
  end

  assign colAddressWrite_Y = col;
  assign colAddressWrite_X = col[XA_W-1:0];
  assign writeEn_X         = (state == WR_X);
  assign writeEn_Y         = (state == WR_Y);
  assign weightMemInput_X  = colData;
  assign weightMemInput_Y  = colData;
  assign gateReset         = (state != IDLE) && (state != START);
  assign beginCalc         = (state == START);
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: full loads, stalls, ignored restarts, mid-load reset, bit-exact words.
module tb_weight_loader;

  localparam int BW = 18;
  localparam int HS = 16;
  localparam int LW = BW * HS;
  localparam int NW = 304;

  logic          clock = 1'b0;
  logic          reset;
  logic          loadStart;
  logic [BW-1:0] wordIn;
  logic          wordValid;
  logic          wordReady;
  logic [0:0]    colAddressWrite_X;
  logic [3:0]    colAddressWrite_Y;
  logic          writeEn_X;
  logic          writeEn_Y;
  logic [LW-1:0] weightMemInput_X;
  logic [LW-1:0] weightMemInput_Y;
  logic [LW-1:0] biasVec;
  logic          gateReset;
  logic          beginCalc;
  logic          busy;

  weight_loader dut (
    .clock             (clock),
    .reset             (reset),
    .loadStart         (loadStart),
    .wordIn            (wordIn),
    .wordValid         (wordValid),
    .wordReady         (wordReady),
    .colAddressWrite_X (colAddressWrite_X),
    .colAddressWrite_Y (colAddressWrite_Y),
    .writeEn_X         (writeEn_X),
    .writeEn_Y         (writeEn_Y),
    .weightMemInput_X  (weightMemInput_X),
    .weightMemInput_Y  (weightMemInput_Y),
    .biasVec           (biasVec),
    .gateReset         (gateReset),
    .beginCalc         (beginCalc),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nX, nY, nBegin, nAcc, beginCyc, startCyc, bothWr, gateInStart;
  int wrLogX[4];
  logic [LW-1:0] ramX[2];
  logic [LW-1:0] ramY[16];
  logic [BW-1:0] words[NW];
  logic [LW-1:0] e;

  always @(posedge clock) cyc++;

  // Behavioural RAM + event counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (writeEn_X) begin
      ramX[colAddressWrite_X] = weightMemInput_X;
      if (nX < 4) wrLogX[nX] = int'(colAddressWrite_X);
      nX++;
    end
    if (writeEn_Y) begin
      ramY[colAddressWrite_Y] = weightMemInput_Y;
      nY++;
    end
    if (writeEn_X && writeEn_Y) bothWr++;
    if (beginCalc) begin
      nBegin++;
      beginCyc = cyc - startCyc;
      if (gateReset) gateInStart++;
    end
    if (wordValid && wordReady) nAcc++;
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearStats();
    nX = 0; nY = 0; nBegin = 0; nAcc = 0; beginCyc = -1; bothWr = 0; gateInStart = 0;
    for (int i = 0; i < 4; i++) wrLogX[i] = -1;
    for (int i = 0; i < 2; i++) ramX[i] = '0;
    for (int i = 0; i < 16; i++) ramY[i] = '0;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < NW; i++) words[i] = BW'(base + i);
  endtask

  function automatic logic [LW-1:0] colExp(input int base);
    logic [LW-1:0] r;
    r = '0;
    for (int l = 0; l < HS; l++) r[l*BW +: BW] = BW'(base + l);
    return r;
  endfunction

  task automatic startLoad();
    loadStart = 1'b1;
    startCyc = cyc;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic sendWord(input logic [BW-1:0] w, input bit gap, input bit pokeStart);
    bit rdy;
    int t;
    wordIn = w;
    wordValid = 1'b1;
    if (pokeStart) loadStart = 1'b1;
    t = 0;
    do begin
      rdy = wordReady;
      tick();
      t++;
    end while (!rdy && t < 64);
    loadStart = 1'b0;
    if (!rdy) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    if (gap) begin
      wordValid = 1'b0;
      tick();
    end
  endtask

  task automatic sendRange(input int first, input int last, input bit gap, input int pokeAt);
    for (int i = first; i <= last; i++) sendWord(words[i], gap, i == pokeAt);
    wordValid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int t;
    t = 0;
    while (busy && t < 40) begin
      tick();
      t++;
    end
    check({tag, "_idle"}, LW'(busy), '0);
  endtask

  task automatic checkAll(input string tag, input int base);
    for (int c = 0; c < 2; c++)
      check($sformatf("%s_x%0d", tag, c), ramX[c], colExp(base + c*HS));
    for (int c = 0; c < 16; c++)
      check($sformatf("%s_y%0d", tag, c), ramY[c], colExp(base + 32 + c*HS));
    check({tag, "_bias"}, biasVec, colExp(base + 288));
  endtask

  task automatic fullLoad(input string tag, input int base, input bit gap, input int pokeAt);
    fill(base);
    clearStats();
    startLoad();
    sendRange(0, NW-1, gap, pokeAt);
    waitIdle(tag);
  endtask

  initial begin
    reset = 1'b1; loadStart = 1'b0; wordValid = 1'b0; wordIn = '0;
    clearStats();
    tick(); tick();
    check("rst_busy", LW'(busy), '0);
    check("rst_ready", LW'(wordReady), '0);
    check("rst_gate", LW'({gateReset, beginCalc, writeEn_X, writeEn_Y}), '0);
    check("rst_bias", biasVec, '0);
    check("rst_colx", weightMemInput_X, '0);
    @(negedge clock) reset = 1'b0;
    tick();

    // 1: running index, no stalls
    fill(0);
    clearStats();
    startLoad();
    check("t1_gate_loading", LW'(gateReset), LW'(1));
    check("t1_busy", LW'(busy), LW'(1));
    sendRange(0, NW-1, 1'b0, -1);
    waitIdle("t1");
    checkAll("t1", 0);
    check("t1_nx", LW'(nX), LW'(2));
    check("t1_ny", LW'(nY), LW'(16));
    check("t1_nbegin", LW'(nBegin), LW'(1));
    check("t1_begin_cyc", LW'(beginCyc), LW'(323));
    check("t1_nacc", LW'(nAcc), LW'(304));
    check("t1_both_wr", LW'(bothWr), '0);
    check("t1_gate_in_start", LW'(gateInStart), '0);

    // 2: wordValid toggling
    fullLoad("t2", 1000, 1'b1, -1);
    checkAll("t2", 1000);
    check("t2_nacc", LW'(nAcc), LW'(304));
    check("t2_nx", LW'(nX), LW'(2));
    check("t2_ny", LW'(nY), LW'(16));

    // 3: loadStart during FILL_Y is ignored
    fullLoad("t3", 5000, 1'b0, 100);
    checkAll("t3", 5000);
    check("t3_nacc", LW'(nAcc), LW'(304));
    check("t3_ny", LW'(nY), LW'(16));
    check("t3_nbegin", LW'(nBegin), LW'(1));
    tick(); tick();
    check("t3_no_restart", LW'(busy), '0);

    // 4: async reset in Y column 5, then a clean reload
    fill(7000);
    clearStats();
    startLoad();
    sendRange(0, 114, 1'b0, -1);
    check("t4_addr_pre", LW'(colAddressWrite_Y), LW'(5));
    #3 reset = 1'b1;
    #1;
    check("t4_rst_busy", LW'(busy), '0);
    check("t4_rst_flags", LW'({gateReset, wordReady, beginCalc, writeEn_X, writeEn_Y}), '0);
    check("t4_rst_addr", LW'(colAddressWrite_Y), '0);
    check("t4_rst_coly", weightMemInput_Y, '0);
    check("t4_rst_bias", biasVec, '0);
    @(negedge clock) reset = 1'b0;
    tick();
    fullLoad("t4b", 9000, 1'b0, -1);
    check("t4_first_x", LW'(wrLogX[0]), '0);
    check("t4_second_x", LW'(wrLogX[1]), LW'(1));
    checkAll("t4b", 9000);

    // 5: back-to-back loads
    fullLoad("t5a", 11000, 1'b0, -1);
    fullLoad("t5b", 13000, 1'b0, -1);
    checkAll("t5b", 13000);
    check("t5_nbegin", LW'(nBegin), LW'(1));

    // 6: extreme words land bit-exact
    fill(20000);
    words[0] = 18'h20000; words[7] = 18'h00001; words[15] = 18'h1FFFF;
    words[288] = 18'h20000; words[295] = 18'h00001; words[303] = 18'h1FFFF;
    clearStats();
    startLoad();
    sendRange(0, NW-1, 1'b0, -1);
    waitIdle("t6");
    e = colExp(20000);
    e[0 +: BW] = 18'h20000; e[7*BW +: BW] = 18'h00001; e[15*BW +: BW] = 18'h1FFFF;
    check("t6_x0", ramX[0], e);
    check("t6_x1", ramX[1], colExp(20016));
    e = colExp(20288);
    e[0 +: BW] = 18'h20000; e[7*BW +: BW] = 18'h00001; e[15*BW +: BW] = 18'h1FFFF;
    check("t6_bias", biasVec, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
